// File: rtl/io_responder.sv
// CPU-facing IO responder: RAM/IO decode, UART RX/TX byte FIFOs, cycle counter, stop flag.
// Latency: one cycle for CPU reads (registered source select); ram_we is combinational.
// Backpressure: rx_ready drops when RX is full; tx_full tells the system to stall rdy_in.

// Byte FIFO with wrap-bit pointers; a push into a full FIFO lands only when a pop frees a slot the same cycle.
module io_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_push_dat,
  input  logic       i_pop,
  output logic [7:0] o_head_dat,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [DEPTH];
  logic        w_pop_ok;
  logic        w_push_ok;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop_ok   = i_pop && !o_empty;
  assign w_push_ok  = i_push && (!o_full || w_pop_ok);
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO at once so no stale byte can leak out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end
endmodule

module io_responder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  ram_dout,
  output logic        ram_we,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tx_full,
  output logic        program_stop
);
  logic        w_io;
  logic        w_io_rd;
  logic        w_io_wr;
  logic        w_a_data;
  logic        w_a_cnt0;
  logic        w_rx_pop;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [7:0]  w_rx_head;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_tx_empty;
  logic        w_stop_set;
  logic [7:0]  w_rd_byte;
  logic        w_unused;

  logic [31:0] r_cnt;
  logic [23:0] r_snap;
  logic [7:0]  r_io_byte;
  logic        r_src_io;
  logic        r_stop;

  // Only bits 17:0 are decoded; bits 17:16 == 2'b11 select the IO window.
  assign w_io     = rdy_in && (mem_a[17:16] == 2'b11);
  assign w_io_rd  = w_io && !mem_wr;
  assign w_io_wr  = w_io && mem_wr;
  assign w_a_data = (mem_a[15:0] == 16'h0000);
  assign w_a_cnt0 = (mem_a[15:0] == 16'h0004);
  assign w_unused = &{1'b0, mem_a[31:18]};

  assign ram_we     = rdy_in && mem_wr && !w_io;
  assign w_rx_pop   = w_io_rd && w_a_data;
  assign w_tx_push  = w_io_wr && w_a_data && (mem_dout != 8'h00);
  assign w_stop_set = w_io_wr && w_a_cnt0;

  assign rx_ready     = !w_rx_full;
  assign tx_valid     = !w_tx_empty;
  assign w_tx_pop     = tx_valid && tx_ready;
  assign program_stop = r_stop;
  assign mem_din      = r_src_io ? r_io_byte : ram_dout;

  io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk      (clk_in),
    .i_rst_n    (rst_in),
    .i_push     (rx_valid),
    .i_push_dat (rx_data),
    .i_pop      (w_rx_pop),
    .o_head_dat (w_rx_head),
    .o_full     (w_rx_full),
    .o_empty    (w_rx_empty)
  );

  io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk      (clk_in),
    .i_rst_n    (rst_in),
    .i_push     (w_tx_push),
    .i_push_dat (mem_dout),
    .i_pop      (w_tx_pop),
    .o_head_dat (tx_data),
    .o_full     (tx_full),
    .o_empty    (w_tx_empty)
  );

  // IO read mux: byte 0 of the counter comes live, bytes 1..3 from the snapshot taken with it.
  always_comb begin
    w_rd_byte = 8'h00;
    if (w_io_rd) begin
      case (mem_a[15:0])
        16'h0000: w_rd_byte = w_rx_empty ? 8'h00 : w_rx_head;
        16'h0004: w_rd_byte = r_cnt[7:0];
        16'h0005: w_rd_byte = r_snap[7:0];
        16'h0006: w_rd_byte = r_snap[15:8];
        16'h0007: w_rd_byte = r_snap[23:16];
        default:  w_rd_byte = 8'h00;
      endcase
    end
  end

  // Free-running cycle counter, independent of bus activity.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_cnt <= '0;
    else         r_cnt <= r_cnt + 32'd1;
  end

  // Read-data register, source select and counter snapshot for the next-cycle return.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_io_byte <= 8'h00;
      r_src_io  <= 1'b0;
      r_snap    <= '0;
    end else begin
      r_io_byte <= w_rd_byte;
      r_src_io  <= w_io;
      if (w_io_rd && w_a_cnt0) r_snap <= r_cnt[31:8];
    end
  end

  // Sticky program-end flag; only reset clears it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)         r_stop <= 1'b0;
    else if (w_stop_set) r_stop <= 1'b1;
  end
endmodule
